// File: rtl/ripple_count_ctrl_if.sv
// ============================================================================
// Module   : ripple_count_ctrl_if
// Brief    : Control and ripple-counter pin bundle for ripple_count_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ripple_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_tick;
  logic             cnt_rst;
  logic [WIDTH-1:0] count_q;
  logic             busy;
  logic             done;
  logic             err;

  // Environment side: control logic plus the counter's count output
  modport master (
    output start, abort, target, cnt_val,
    input  cnt_tick, cnt_rst, count_q, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  start, abort, target, cnt_val,
    output cnt_tick, cnt_rst, count_q, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/ripple_count_ctrl.sv
// ============================================================================
// Module   : ripple_count_ctrl
// Brief    : Clears an external ripple counter, issues target ticks, and
//            samples its settled count. Optional check: RIPPLE_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ripple_count_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  ripple_count_ctrl_if.slave  bus
);

  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0] c_wait_last = WW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_CWAIT  = 3'd2,
    S_TICK   = 3'd3,
    S_TWAIT  = 3'd4,
    S_SAMPLE = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           r_state;
  logic [WW-1:0]    r_wait;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_crst;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_shadow_inc;

  assign w_shadow_inc = r_shadow + WIDTH'(1);

`ifdef RIPPLE_CHECK_EN
  logic r_err;
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cnt_tick = r_tick;
  assign bus.cnt_rst  = r_crst;
  assign bus.count_q  = r_count;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

  // cnt_rst resets high so the external counter is held clear during rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_tgt    <= '0;
      r_shadow <= '0;
      r_count  <= '0;
      r_tick   <= 1'b0;
      r_crst   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef RIPPLE_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
      r_crst <= 1'b0;
      r_done <= 1'b0;
      if (r_state != S_IDLE && bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_tgt    <= bus.target;
              r_shadow <= '0;
              r_crst   <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= S_CLEAR;
`ifdef RIPPLE_CHECK_EN
              r_err    <= 1'b0;
`endif
            end
          end
          S_CLEAR: begin
            r_wait  <= '0;
            r_state <= S_CWAIT;
          end
          S_CWAIT: begin
            if (r_wait == c_wait_last) begin
`ifdef RIPPLE_CHECK_EN
              if (bus.cnt_val != '0) r_err <= 1'b1;
`endif
              if (r_tgt == '0) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_tick  <= 1'b1;
                r_state <= S_TICK;
              end
            end else begin
              r_wait <= r_wait + WW'(1);
            end
          end
          S_TICK: begin
            r_wait  <= '0;
            r_state <= S_TWAIT;
          end
          S_TWAIT: begin
            if (r_wait == c_wait_last) r_state <= S_SAMPLE;
            else                       r_wait  <= r_wait + WW'(1);
          end
          S_SAMPLE: begin
            r_count  <= bus.cnt_val;
            r_shadow <= w_shadow_inc;
`ifdef RIPPLE_CHECK_EN
            if (bus.cnt_val != w_shadow_inc) r_err <= 1'b1;
`endif
            if (w_shadow_inc == r_tgt) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_tick  <= 1'b1;
              r_state <= S_TICK;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ripple_count_ctrl.sv
// ============================================================================
// Module   : tb_ripple_count_ctrl
// Brief    : Scoreboard bench for ripple_count_ctrl with a modelled ripple counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ripple_count_ctrl;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;

`ifdef RIPPLE_CHECK_EN
  localparam logic CHK_ERR = 1'b1;
`else
  localparam logic CHK_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ripple_count_ctrl_if #(.WIDTH(WIDTH)) bif ();

  ripple_count_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Asynchronous ripple counter model with a small output settle delay
  logic [WIDTH-1:0] model_cnt = '0;
  logic             stuck     = 1'b0;
  always @(posedge bif.cnt_tick or posedge bif.cnt_rst)
    if (bif.cnt_rst) model_cnt <= '0;
    else             model_cnt <= model_cnt + 4'd1;
  assign #2 bif.cnt_val = stuck ? 4'd0 : model_cnt;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tick_total = 0;
  always @(posedge bif.cnt_tick) tick_total <= tick_total + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;
  int tick_base = 0;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    int               ticks;
    int               lat;
    logic             err;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scores every done pulse against the oldest expectation
  initial begin : monitor
    exp_t e;
    bit   after_done;
    after_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.cnt_tick === 1'b1) chk("tick_vs_cnt_rst", bif.cnt_rst, 0);
      if (after_done) begin
        chk("busy_after_done", bif.busy, 0);
        after_done = 1'b0;
      end
      if (bif.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("count_q", bif.count_q, e.cnt);
          chk("tick_count", tick_total - tick_base, e.ticks);
          chk("done_latency", cyc - start_cyc, e.lat);
          chk("err_at_done", bif.err, e.err);
        end
        after_done = 1'b1;
      end
    end
  end

  task automatic do_start(input logic [WIDTH-1:0] tgt, input bit push,
                          input logic [WIDTH-1:0] exp_cnt, input int exp_ticks,
                          input int exp_lat, input logic exp_err);
    exp_t e;
    @(posedge clk); #1;
    bif.target = tgt;
    bif.start  = 1'b1;
    start_cyc  = cyc;
    tick_base  = tick_total;
    if (push) begin
      e.cnt = exp_cnt; e.ticks = exp_ticks; e.lat = exp_lat; e.err = exp_err;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bif.start  = 1'b0;
    bif.target = ~tgt;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bif.busy && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, (k < 300) ? 1 : 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int k;
    bif.start  = 1'b0;
    bif.abort  = 1'b0;
    bif.target = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt_rst", bif.cnt_rst, 1);
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_count_q", bif.count_q, 0);
    chk("rst_cnt_tick", bif.cnt_tick, 0);
    chk("rst_err", bif.err, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("cnt_rst_after_release", bif.cnt_rst, 0);

    // target=3: 2+2+3*4 = 16
    do_start(4'd3, 1'b1, 4'd3, 3, 16, 1'b0);
    wait_idle("idle_t3");

    // target=0: clear only, count_q keeps the previous sample
    do_start(4'd0, 1'b1, 4'd3, 0, 4, 1'b0);
    wait_idle("idle_t0");

    // target=15 with an ignored second start mid-run: 2+2+15*4 = 64
    fork
      do_start(4'd15, 1'b1, 4'd15, 15, 64, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1;
        bif.start  = 1'b1;
        bif.target = 4'd3;
        @(posedge clk); #1;
        bif.start  = 1'b0;
      end
    join
    wait_idle("idle_t15");

    // abort once count_q reaches 2 in a target=5 run
    do_start(4'd5, 1'b0, 4'd0, 0, 0, 1'b0);
    k = 0;
    while (bif.count_q != 4'd2 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_count_2", (k < 100) ? 1 : 0, 1);
    bif.abort = 1'b1;
    @(posedge clk); #1;
    bif.abort = 1'b0;
    chk("abort_busy", bif.busy, 0);
    chk("abort_cnt_tick", bif.cnt_tick, 0);
    chk("abort_count_q", bif.count_q, 2);
    chk("abort_done", bif.done, 0);
    repeat (30) @(posedge clk);
    #1;
    do_start(4'd1, 1'b1, 4'd1, 1, 8, 1'b0);
    wait_idle("idle_t1");

    // abort and start together in IDLE: not accepted
    bif.start  = 1'b1;
    bif.abort  = 1'b1;
    bif.target = 4'd2;
    @(posedge clk); #1;
    bif.start = 1'b0;
    bif.abort = 1'b0;
    chk("abort_start_busy", bif.busy, 0);
    chk("abort_start_cnt_rst", bif.cnt_rst, 0);

    // rst mid-run
    do_start(4'd4, 1'b0, 4'd0, 0, 0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", bif.busy, 0);
    chk("midrst_cnt_rst", bif.cnt_rst, 1);
    chk("midrst_count_q", bif.count_q, 0);
    chk("midrst_cnt_tick", bif.cnt_tick, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // stuck counter: err only when the checker is built
    stuck = 1'b1;
    do_start(4'd2, 1'b1, 4'd0, 2, 12, CHK_ERR);
    wait_idle("idle_stuck");
    stuck = 1'b0;
    chk("err_sticky", bif.err, CHK_ERR);
    do_start(4'd1, 1'b1, 4'd1, 1, 8, 1'b0);
    chk("err_clear_on_start", bif.err, 0);
    wait_idle("idle_after_stuck");

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
